// File: rtl/cell_path_bist.sv
// cell_path_bist: LFSR pattern source and MISR response compactor wrapped
// around a mapped standard-cell path.
// Optional feature macro: GOLDEN_CMP_EN adds i_golden / o_pass and the
// end-of-run signature comparator.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for i_start; outputs hold the last run's results
// S_RUN   | one pattern per cycle on o_pat_out, NPAT cycles
// S_DRAIN | LAT cycles letting in-flight responses reach the MISR
// S_DONE  | one-cycle o_done pulse; signature is final
module cell_path_bist #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               NPAT  = 255,
    parameter int               LAT   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_pat_out,
    input  logic [WIDTH-1:0] i_resp_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_signature
`ifdef GOLDEN_CMP_EN
    ,
    input  logic [WIDTH-1:0] i_golden,
    output logic             o_pass
`endif
);

    localparam int CW = $clog2(NPAT + 1);
    localparam int PW = (LAT > 0) ? LAT : 1;
    localparam logic [2:0] DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pat;
    logic [WIDTH-1:0] r_sig;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_vpipe;
    logic [2:0]       r_drain;
    logic             w_run;
    logic             w_last_pat;
    logic             w_cmp_en;
    logic [WIDTH-1:0] w_pat_adv;
    logic [WIDTH-1:0] w_sig_next;

    assign w_run      = (r_state == S_RUN);
    assign w_last_pat = (r_cnt == CW'(NPAT - 1));
    // With no pipeline stages the response lines up with the pattern itself.
    assign w_cmp_en   = (LAT == 0) ? w_run : r_vpipe[PW-1];
    assign w_pat_adv  = {r_pat[WIDTH-2:0], ^(r_pat & TAPS)};
    assign w_sig_next = w_cmp_en ? ({r_sig[WIDTH-2:0], ^(r_sig & TAPS)} ^ i_resp_in)
                                 : r_sig;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_RUN;
            S_RUN:   if (w_last_pat) w_state_next = (LAT > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (r_drain == 3'd0) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pattern generator, pattern counter, valid pipe, drain timer and MISR.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat   <= '0;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_vpipe <= '0;
            r_drain <= '0;
        end else begin
            r_vpipe <= (r_vpipe << 1) | PW'(w_run);
            r_sig   <= w_sig_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        // An all-zero seed would lock the LFSR.
                        r_pat <= (i_seed == '0) ? WIDTH'(1) : i_seed;
                        r_sig <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_pat <= w_pat_adv;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_state_next == S_DRAIN) r_drain <= DRAIN_LOAD;
                end
                S_DRAIN: begin
                    if (r_drain != 3'd0) r_drain <= r_drain - 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef GOLDEN_CMP_EN
    logic r_pass;

    // Compare the signature being written on the edge that enters DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_pass <= 1'b0;
        end else if (w_state_next == S_DONE && r_state != S_DONE) begin
            r_pass <= (w_sig_next == i_golden);
        end
    end

    assign o_pass = r_pass;
`endif

    assign o_pat_out   = r_pat;
    assign o_signature = r_sig;
    assign o_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: doc/cell_path_bist.md
# cell_path_bist

Built-in self-test wrapper for a gate-level path mapped onto the team's standard-cell library. An LFSR drives patterns into the combinational or registered cell network under test, and a MISR compacts the network's responses into a signature. It sits directly around the mapped cells: its pattern output feeds the cell inputs, and its response input consumes the cell outputs. Used in the timing flow to exercise synthesized paths at speed and compare against a golden signature.

## Interface
- WIDTH, 8, pattern, response and signature width (>=2)
- TAPS, 8'hB8, LFSR/MISR feedback mask; bit i set means state bit i feeds the XOR; default is maximal-length for WIDTH=8
- NPAT, 255, number of patterns applied per run (1..2^WIDTH-1)
- LAT, 1, register stages between pat_out and resp_in (0..7)

- C  in  1  clock, rising edge
- R  in  1  asynchronous reset, active-low
- start  in  1  run request, sampled in IDLE only
- seed  in  WIDTH  LFSR seed, sampled with start
- pat_out  out  WIDTH  pattern driven to the cell network
- resp_in  in  WIDTH  response from the cell network
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse on completion
- signature  out  WIDTH  MISR state; final value held from done until next start
- golden  in  WIDTH  expected signature (only with GOLDEN_CMP_EN)
- pass  out  1  compare result (only with GOLDEN_CMP_EN)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- Reset values: pat_out=0, signature=0, busy=0, done=0, pass=0, counter=0, valid pipe=0.
- IDLE, edge with start=1:
  - pat_out loads seed, or 1 if seed==0 (avoids LFSR lockup).
  - signature clears to 0 and counter clears to 0.
  - Go to RUN.
- IDLE, start=0: all outputs hold.
- RUN, each edge:
  - pat_out advances to {pat_out[WIDTH-2:0], ^(pat_out & TAPS)}.
  - Counter increments.
  - On the edge where counter==NPAT-1, go to DRAIN if LAT>0, else to DONE.
  - Exactly NPAT patterns are presented, one per RUN cycle.
- Valid pipe: a bit that is 1 for each RUN cycle, delayed LAT edges.
  - Compaction enable for LAT=0 is the RUN state itself.
  - When enabled at an edge: signature <= {signature[WIDTH-2:0], ^(signature & TAPS)} ^ resp_in.
  - When not enabled, signature holds.
- DRAIN lasts exactly LAT cycles, pat_out holds, then go to DONE.
- DONE lasts one cycle: done=1, then return to IDLE.
- busy is 1 in RUN and DRAIN, 0 otherwise.
- start is ignored outside IDLE. start during DONE is also ignored.
- Counter width is clog2(NPAT+1) bits. No wrap occurs within a run.
- Deasserting R mid-run aborts immediately to reset values. No partial signature is retained.

## Timing
- start edge to first pattern on pat_out: 1 edge (visible in the first RUN cycle).
- busy duration: NPAT+LAT cycles.
- done rises NPAT+LAT cycles after the start edge. signature is final in the same cycle.
- With GOLDEN_CMP_EN, pass updates on the edge entering DONE and is visible with done.
- Back-to-back runs: earliest next start is the first IDLE cycle after DONE.

## Configuration
- GOLDEN_CMP_EN defined:
  - Adds the golden and pass ports.
  - pass <= (next signature == golden), registered on entry to DONE.
  - pass clears to 0 on a start edge and on reset, and holds between runs.
- GOLDEN_CMP_EN undefined:
  - golden and pass ports are absent; no comparator logic.
  - All other behaviour is identical.

## Test plan
- Reset mid-RUN (WIDTH=8, seed 8'h01, R low at cycle 3) -> pat_out=00, signature=00, busy=0, state IDLE; new start then behaves as a fresh run.
- Defaults, seed 8'h01, LAT=0, resp_in tied 0 -> pat_out sequence 01,02,04,08,11,23 over first six RUN cycles; busy high 255 cycles; done pulse; signature=00.
- seed 8'h00 -> first pattern 01; full run with NPAT=255 visits 255 distinct nonzero values; pat_out returns to 01 after the last advance.
- NPAT=1, LAT=0, resp_in=pat_out loopback, seed 8'h5A -> busy 1 cycle, done on next cycle, signature=5A.
- NPAT=2, LAT=0, loopback, seed 8'h01 -> signature=00; with LAT=1 (one external DFF stage) -> busy 3 cycles, signature=00, done 3 cycles after start.
- GOLDEN_CMP_EN, previous case with golden=00 -> pass=1 with done; repeat with golden=01 -> pass=0; start held high during RUN -> no restart, single done.
